// File: rtl/freq_meter_pkg.sv
// Shared encodings and helpers for the frequency/period meter.
// sat_inc works on a 64-bit container so any CNT_W up to 64 can share it.
package freq_meter_pkg;

    typedef enum logic {
        S_ARM     = 1'b0,
        S_MEASURE = 1'b1
    } state_e;

    localparam logic MODE_GATE   = 1'b0;
    localparam logic MODE_PERIOD = 1'b1;

    localparam int SAT_W = 64;

    // Increment by one when en is set, but never past max_val.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] val,
        input logic [SAT_W-1:0] max_val,
        input logic             en
    );
        if (en && (val < max_val)) begin
            return val + SAT_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer followed by a registered previous value; EDGE
// pulses for one cycle on each synchronized rising edge of SIG_IN.
module sig_sync_edge (
    input  logic CLK,
    input  logic RST_N,
    input  logic SIG_IN,
    output logic EDGE
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = SIG_IN;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign EDGE = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: gated edge count over GATE_CYCLES, or period in CLK
// cycles between consecutive rising edges, selected by MODE.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 200000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SIG_IN,
    input  logic             MODE,
    output logic [CNT_W-1:0] RESULT,
    output logic             VALID,
    output logic             OVF,
    output logic             TIMEOUT,
    output state_e           dbg_state
);

    localparam int unsigned      WIN_W       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(GATE_CYCLES - 1);
    localparam logic [SAT_W-1:0] CNT_MAX     = SAT_W'({CNT_W{1'b1}});
    localparam logic [SAT_W-1:0] TIMEOUT_LIM = SAT_W'(TIMEOUT_CYCLES);

    logic sig_edge;

    sig_sync_edge u_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .SIG_IN (SIG_IN),
        .EDGE   (sig_edge)
    );

    state_e             state_q,   state_d;
    logic               mode_q,    mode_d;
    logic [WIN_W-1:0]   win_q,     win_d;
    logic [CNT_W-1:0]   edgcnt_q,  edgcnt_d;
    logic [CNT_W-1:0]   pcnt_q,    pcnt_d;
    logic               sat_q,     sat_d;
    logic [CNT_W-1:0]   result_q,  result_d;
    logic               valid_q,   valid_d;
    logic               ovf_q,     ovf_d;
    logic               timeout_q, timeout_d;

    logic [SAT_W-1:0]   edg_inc;
    logic [SAT_W-1:0]   pcnt_inc;
    logic               edg_lost;
    logic               pcnt_lost;

    always_comb begin
        edg_inc   = sat_inc(SAT_W'(edgcnt_q), CNT_MAX, sig_edge);
        pcnt_inc  = sat_inc(SAT_W'(pcnt_q), CNT_MAX, 1'b1);
        // An increment that left the value unchanged was clipped by saturation.
        edg_lost  = sig_edge && (edg_inc == SAT_W'(edgcnt_q));
        pcnt_lost = (pcnt_inc == SAT_W'(pcnt_q));

        mode_d    = MODE;
        state_d   = state_q;
        win_d     = win_q;
        edgcnt_d  = edgcnt_q;
        pcnt_d    = pcnt_q;
        sat_d     = sat_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        timeout_d = timeout_q;

        if (mode_q != MODE) begin
            // Mode change: drop the measurement in flight, keep the last result.
            state_d  = S_ARM;
            win_d    = '0;
            edgcnt_d = '0;
            pcnt_d   = '0;
            sat_d    = 1'b0;
        end else if (mode_q == MODE_GATE) begin
            state_d = S_ARM;
            pcnt_d  = '0;
            if (win_q == WIN_LAST) begin
                result_d  = edg_inc[CNT_W-1:0];
                ovf_d     = sat_q | edg_lost;
                timeout_d = 1'b0;
                valid_d   = 1'b1;
                win_d     = '0;
                edgcnt_d  = '0;
                sat_d     = 1'b0;
            end else begin
                win_d    = win_q + WIN_W'(1);
                edgcnt_d = edg_inc[CNT_W-1:0];
                sat_d    = sat_q | edg_lost;
            end
        end else begin
            win_d    = '0;
            edgcnt_d = '0;
            // The closing edge of one period opens the next, so no re-arm here.
            if (sig_edge) begin
                if (state_q == S_MEASURE) begin
                    result_d  = pcnt_q;
                    ovf_d     = sat_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                end
                state_d = S_MEASURE;
                pcnt_d  = CNT_W'(1);
                sat_d   = 1'b0;
            end else if (pcnt_inc >= TIMEOUT_LIM) begin
                result_d  = '0;
                ovf_d     = 1'b0;
                timeout_d = 1'b1;
                valid_d   = 1'b1;
                state_d   = S_ARM;
                pcnt_d    = '0;
                sat_d     = 1'b0;
            end else begin
                pcnt_d = pcnt_inc[CNT_W-1:0];
                sat_d  = sat_q | pcnt_lost;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q    <= MODE;
            state_q   <= S_ARM;
            win_q     <= '0;
            edgcnt_q  <= '0;
            pcnt_q    <= '0;
            sat_q     <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            state_q   <= state_d;
            win_q     <= win_d;
            edgcnt_q  <= edgcnt_d;
            pcnt_q    <= pcnt_d;
            sat_q     <= sat_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
        end
    end

    assign RESULT    = result_q;
    assign VALID     = valid_q;
    assign OVF       = ovf_q;
    assign TIMEOUT   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: gated count, period, timeout, reset and
// mode-change aborts, plus a 4-bit instance for saturation.
module tb_freq_meter;
  import freq_meter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mode;
  logic sig_in;
  logic sig_in4;

  logic [31:0] result;
  logic        valid, ovf, timeout;
  state_e      dbg_state;
  logic [3:0]  result4;
  logic        valid4, ovf4, timeout4;
  state_e      dbg_state4;

  freq_meter #(.GATE_CYCLES(100), .TIMEOUT_CYCLES(1000), .CNT_W(32)) dut (
    .CLK(clk), .RST_N(rst_n), .SIG_IN(sig_in), .MODE(mode),
    .RESULT(result), .VALID(valid), .OVF(ovf), .TIMEOUT(timeout),
    .dbg_state(dbg_state)
  );

  freq_meter #(.GATE_CYCLES(100), .TIMEOUT_CYCLES(1000), .CNT_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .SIG_IN(sig_in4), .MODE(mode),
    .RESULT(result4), .VALID(valid4), .OVF(ovf4), .TIMEOUT(timeout4),
    .dbg_state(dbg_state4)
  );

  // bookkeeping
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0;
  int v_prev;

  // square-wave generators: high for gen_hi, low for gen_lo; gen_hi == 0 holds 0
  int gen_hi = 0, gen_lo = 0, gen_ph = 0;
  int gen4_hi = 0, gen4_lo = 0, gen4_ph = 0;

  // last VALID seen per instance (0 = 32-bit, 1 = 4-bit)
  logic        v_seen[2];
  int          v_cyc[2];
  logic [31:0] v_res[2];
  logic        v_ovf[2];
  logic        v_to[2];

  // scoreboard of expected RESULT values
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gen_update();
    if (gen_hi == 0) sig_in = 1'b0;
    else begin
      gen_ph = (gen_ph + 1) % (gen_hi + gen_lo);
      sig_in = (gen_ph < gen_hi);
    end
    if (gen4_hi == 0) sig_in4 = 1'b0;
    else begin
      gen4_ph = (gen4_ph + 1) % (gen4_hi + gen4_lo);
      sig_in4 = (gen4_ph < gen4_hi);
    end
  endtask

  // one clock: DUT samples on posedge, outputs observed on negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (valid) begin
      v_seen[0] = 1'b1; v_cyc[0] = cyc; v_res[0] = result;
      v_ovf[0] = ovf; v_to[0] = timeout;
    end
    if (valid4) begin
      v_seen[1] = 1'b1; v_cyc[1] = cyc; v_res[1] = 32'(result4);
      v_ovf[1] = ovf4; v_to[1] = timeout4;
    end
    gen_update();
  endtask

  task automatic wait_valid(input string tag, input int idx, input int limit);
    int n;
    n = 0;
    v_seen[idx] = 1'b0;
    while (!v_seen[idx] && n < limit) begin
      step();
      n++;
    end
    checks++;
    assert (v_seen[idx] === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed no VALID within %0d cycles, expected one", tag, limit);
    end
  endtask

  task automatic check_result(input string tag, input int idx);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    check(tag, 64'(v_res[idx]), 64'(exp));
  endtask

  initial begin
    rst_n   = 1'b0;
    mode    = MODE_GATE;
    sig_in  = 1'b0;
    sig_in4 = 1'b0;
    v_seen[0] = 1'b0; v_seen[1] = 1'b0;

    // reset state
    repeat (3) step();
    check("rst_result", 64'(result), 0);
    check("rst_valid", 64'(valid), 0);
    check("rst_ovf", 64'(ovf), 0);
    check("rst_timeout", 64'(timeout), 0);
    check("rst_state", 64'(dbg_state), 64'(S_ARM));
    check("rst_result4", 64'(result4), 0);
    check("rst_state4", 64'(dbg_state4), 64'(S_ARM));

    // gated mode, period-10 input
    gen_hi = 5; gen_lo = 5; gen_ph = 9;
    rst_n = 1'b1;
    c0 = cyc;
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(32'd10);
      wait_valid("gate_valid", 0, 110);
      check("gate_gap", 64'(v_cyc[0] - ((w == 0) ? c0 : v_prev)), 100);
      check_result("gate_result", 0);
      check("gate_ovf", 64'(v_ovf[0]), 0);
      check("gate_timeout", 64'(v_to[0]), 0);
      v_prev = v_cyc[0];
    end

    // reset pulse mid-window while the input is in its low phase
    repeat (50) step();
    for (int k = 0; k < 10 && gen_ph != 7; k++) step();
    rst_n = 1'b0;
    step();
    check("midrst_result", 64'(result), 0);
    check("midrst_valid", 64'(valid), 0);
    check("midrst_ovf", 64'(ovf), 0);
    check("midrst_timeout", 64'(timeout), 0);
    rst_n = 1'b1;
    c0 = cyc;
    exp_q.push_back(32'd10);
    wait_valid("midrst_valid_after", 0, 120);
    check("midrst_latency", 64'(v_cyc[0] - c0), 100);
    check_result("midrst_fresh_window", 0);

    // switch to period mode at window cycle 60
    repeat (59) step();
    check("switch_hold_result", 64'(result), 10);
    mode = MODE_PERIOD;
    c0 = cyc;
    exp_q.push_back(32'd10);
    wait_valid("switch_first_valid", 0, 35);
    check_result("switch_period_result", 0);
    check("switch_timeout", 64'(v_to[0]), 0);
    check("switch_state", 64'(dbg_state), 64'(S_MEASURE));
    v_prev = v_cyc[0];
    exp_q.push_back(32'd10);
    wait_valid("switch_second_valid", 0, 20);
    check("switch_gap", 64'(v_cyc[0] - v_prev), 10);
    check_result("switch_period_result2", 0);

    // period mode, 37-cycle input from a fresh start
    rst_n = 1'b0;
    sig_in = 1'b0;
    gen_hi = 18; gen_lo = 19; gen_ph = 30;
    step();
    rst_n = 1'b1;
    exp_q.push_back(32'd37);
    wait_valid("per37_first", 0, 100);
    check_result("per37_first_result", 0);
    check("per37_first_ovf", 64'(v_ovf[0]), 0);
    for (int k = 0; k < 3; k++) begin
      v_prev = v_cyc[0];
      exp_q.push_back(32'd37);
      wait_valid("per37_next", 0, 50);
      check("per37_gap", 64'(v_cyc[0] - v_prev), 37);
      check_result("per37_result", 0);
      check("per37_timeout", 64'(v_to[0]), 0);
    end

    // period mode, input held low: timeout every 1000 cycles
    rst_n = 1'b0;
    sig_in = 1'b0;
    gen_hi = 0;
    step();
    rst_n = 1'b1;
    c0 = cyc;
    exp_q.push_back(32'd0);
    wait_valid("to_first", 0, 1010);
    check("to_latency", 64'(v_cyc[0] - c0), 1000);
    check_result("to_result", 0);
    check("to_flag", 64'(v_to[0]), 1);
    check("to_ovf", 64'(v_ovf[0]), 0);
    check("to_state", 64'(dbg_state), 64'(S_ARM));
    v_prev = v_cyc[0];
    exp_q.push_back(32'd0);
    wait_valid("to_second", 0, 1010);
    check("to_repeat_gap", 64'(v_cyc[0] - v_prev), 1000);
    check_result("to_repeat_result", 0);
    check("to_repeat_flag", 64'(v_to[0]), 1);
    gen_hi = 18; gen_lo = 19; gen_ph = 30;
    exp_q.push_back(32'd37);
    wait_valid("to_recover", 0, 120);
    check_result("to_recover_result", 0);
    check("to_recover_flag", 64'(v_to[0]), 0);

    // 4-bit instance: saturation in gated mode, then a clean 3-edge window
    rst_n = 1'b0;
    mode = MODE_GATE;
    sig_in = 1'b0;
    gen_hi = 0;
    gen4_hi = 2; gen4_lo = 3; gen4_ph = 4;
    step();
    rst_n = 1'b1;
    c0 = cyc;
    repeat (90) step();
    gen4_hi = 0;
    exp_q.push_back(32'd15);
    wait_valid("sat_valid", 1, 20);
    check("sat_latency", 64'(v_cyc[1] - c0), 100);
    check_result("sat_result", 1);
    check("sat_ovf", 64'(v_ovf[1]), 1);
    check("sat_timeout", 64'(v_to[1]), 0);
    v_prev = v_cyc[1];
    repeat (5) step();
    gen4_hi = 3; gen4_lo = 3; gen4_ph = 3;
    repeat (18) step();
    gen4_hi = 0;
    exp_q.push_back(32'd3);
    wait_valid("unsat_valid", 1, 100);
    check("unsat_gap", 64'(v_cyc[1] - v_prev), 100);
    check_result("unsat_result", 1);
    check("unsat_ovf", 64'(v_ovf[1]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
